// File: rtl/sort_pkg.sv
// Shared constants and encodings for the sort RAM arbiter slice.
// Holds RAM geometry, requester port ids and arbiter FSM states.
package sort_pkg;

  localparam int AW = 4;
  localparam int DW = 8;

  typedef enum logic {
    PORT_SORT = 1'b0,
    PORT_HOST = 1'b1
  } port_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of both requester ports plus the RAM pins and busy flag.
// slave: arbiter view; master: requesters/RAM view.
interface ram_port_arbiter_if;
  import sort_pkg::*;

  logic          req0;
  logic          lock0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;

  logic          req1;
  logic          lock1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;

  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;
  logic [DW-1:0] ram_q;
  logic          busy;

  modport slave (
    input  req0, lock0, we0, addr0, wdata0,
    input  req1, lock1, we1, addr1, wdata1,
    input  ram_q,
    output gnt0, rvalid0, gnt1, rvalid1,
    output rdata, ram_addr, ram_wdata,
    output ram_wren, busy
  );

  modport master (
    output req0, lock0, we0, addr0, wdata0,
    output req1, lock1, we1, addr1, wdata1,
    output ram_q,
    input  gnt0, rvalid0, gnt1, rvalid1,
    input  rdata, ram_addr, ram_wdata,
    input  ram_wren, busy
  );

endinterface

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep {valid, id} shift register tracking reads in flight.
// Ports: C, R, i_push, i_id in; o_valid, o_id (oldest), o_any out.
module rd_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic C,
  input  logic R,
  input  logic i_push,
  input  logic i_id,
  output logic o_valid,
  output logic o_id,
  output logic o_any
);

  logic [RD_LAT-1:0] r_v;
  logic [RD_LAT-1:0] r_id;
  logic [RD_LAT:0]   w_v_nx;
  logic [RD_LAT:0]   w_id_nx;

  assign w_v_nx  = {r_v, i_push};
  assign w_id_nx = {r_id, i_id};

  always_ff @(posedge C) begin
    if (R) begin
      r_v  <= '0;
      r_id <= '0;
    end else begin
      r_v  <= w_v_nx[RD_LAT-1:0];
      r_id <= w_id_nx[RD_LAT-1:0];
    end
  end

  assign o_valid = r_v[RD_LAT-1];
  assign o_id    = r_id[RD_LAT-1];
  assign o_any   = |r_v;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with locked bursts sharing one 16x8 RAM port.
// Ports: C, R plain; b (slave) carries both requesters and RAM pins.
module ram_port_arbiter
  import sort_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic C,
  input  logic R,
  ram_port_arbiter_if.slave b
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e    r_state;
  logic          r_rr;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic          w_g0;
  logic          w_g1;
  logic          w_force;
  logic          w_cap;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_push;
  logic          w_pv;
  logic          w_pid;
  logic          w_pany;

  assign w_cap = (r_cnt == CW'(MAX_BURST));

  always_comb begin
    w_g0    = 1'b0;
    w_g1    = 1'b0;
    w_force = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_g0 = b.req0 & (~b.req1 | ~r_rr);
        w_g1 = b.req1 & (~b.req0 | r_rr);
      end
      OWN0: begin
        w_force = w_cap & b.req1;
        w_g0    = b.req0 & ~w_force;
      end
      OWN1: begin
        w_force = w_cap & b.req0;
        w_g1    = b.req1 & ~w_force;
      end
      default: ;
    endcase
    if (R) begin
      w_g0 = 1'b0;
      w_g1 = 1'b0;
    end
  end

  // Hold last granted address/data when idle to cut pin toggling.
  always_comb begin
    w_addr  = r_addr;
    w_wdata = r_wdata;
    if (w_g1) begin
      w_addr  = b.addr1;
      w_wdata = b.wdata1;
    end else if (w_g0 || R) begin
      w_addr  = b.addr0;
      w_wdata = b.wdata0;
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_g0 || w_g1) begin
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
      end
      unique case (r_state)
        IDLE: begin
          if (w_g0 || w_g1) begin
            r_rr <= w_g0;
            if (w_g0 ? b.lock0 : b.lock1) begin
              r_state <= w_g0 ? OWN0 : OWN1;
              r_cnt   <= CW'(1);
            end
          end
        end
        OWN0: begin
          if (w_g0 && !w_cap) r_cnt <= r_cnt + 1'b1;
          if (w_force || !b.lock0) r_state <= IDLE;
        end
        OWN1: begin
          if (w_g1 && !w_cap) r_cnt <= r_cnt + 1'b1;
          if (w_force || !b.lock1) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_push = (w_g0 & ~b.we0) | (w_g1 & ~b.we1);

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .C       (C),
    .R       (R),
    .i_push  (w_push),
    .i_id    (w_g1),
    .o_valid (w_pv),
    .o_id    (w_pid),
    .o_any   (w_pany)
  );

  assign b.gnt0      = w_g0;
  assign b.gnt1      = w_g1;
  assign b.ram_addr  = w_addr;
  assign b.ram_wdata = w_wdata;
  assign b.ram_wren  = (w_g0 & b.we0) | (w_g1 & b.we1);
  assign b.rdata     = b.ram_q;
  assign b.rvalid0   = ~R & w_pv & (w_pid == PORT_SORT);
  assign b.rvalid1   = ~R & w_pv & (w_pid == PORT_HOST);
  assign b.busy      = ~R & ((r_state != IDLE) | w_pany);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: vector table on a default instance plus
// hand sequences on a RD_LAT=2, MAX_BURST=4 instance.
module tb_ram_port_arbiter;

  logic C = 1'b0;
  logic R = 1'b1;
  logic ld = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 C = ~C;

  ram_port_arbiter_if ifa ();
  ram_port_arbiter_if ifb ();

  ram_port_arbiter dut_a (
    .C (C),
    .R (R),
    .b (ifa)
  );

  ram_port_arbiter #(
    .RD_LAT    (2),
    .MAX_BURST (4)
  ) dut_b (
    .C (C),
    .R (R),
    .b (ifb)
  );

  // RAM models: mem[i] = 4*i after preload; registered read.
  logic [7:0] mema [16];
  logic [7:0] memb [16];
  logic [7:0] qa;
  logic [7:0] qb1;
  logic [7:0] qb2;

  always @(posedge C) begin
    if (ld) begin
      for (int i = 0; i < 16; i++) begin
        mema[i] <= 8'(i * 4);
        memb[i] <= 8'(i * 4);
      end
    end else begin
      if (ifa.ram_wren) mema[ifa.ram_addr] <= ifa.ram_wdata;
      if (ifb.ram_wren) memb[ifb.ram_addr] <= ifb.ram_wdata;
    end
    qa  <= mema[ifa.ram_addr];
    qb1 <= memb[ifb.ram_addr];
    qb2 <= qb1;
  end

  assign ifa.ram_q = qa;
  assign ifb.ram_q = qb2;

  typedef struct {
    logic       r;
    logic       q0;
    logic       l0;
    logic       w0;
    logic [3:0] a0;
    logic [7:0] d0;
    logic       q1;
    logic       l1;
    logic       w1;
    logic [3:0] a1;
    logic [7:0] d1;
    logic [5:0] ex;
    logic [7:0] erd;
  } vec_t;

  vec_t tv [$];

  function automatic vec_t mk(
    input logic r,
    input logic q0, input logic l0, input logic w0,
    input logic [3:0] a0, input logic [7:0] d0,
    input logic q1, input logic l1, input logic w1,
    input logic [3:0] a1, input logic [7:0] d1,
    input logic [5:0] ex, input logic [7:0] erd);
    vec_t v;
    v.r = r;
    v.q0 = q0; v.l0 = l0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.ex = ex; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic b_idle();
    ifb.req0 = 1'b0; ifb.lock0 = 1'b0; ifb.we0 = 1'b0;
    ifb.addr0 = '0; ifb.wdata0 = '0;
    ifb.req1 = 1'b0; ifb.lock1 = 1'b0; ifb.we1 = 1'b0;
    ifb.addr1 = '0; ifb.wdata1 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first;
    int idle_at;
    int n_g0;
    logic [5:0] o;

    ifa.req0 = 1'b0; ifa.lock0 = 1'b0; ifa.we0 = 1'b0;
    ifa.addr0 = '0; ifa.wdata0 = '0;
    ifa.req1 = 1'b0; ifa.lock1 = 1'b0; ifa.we1 = 1'b0;
    ifa.addr1 = '0; ifa.wdata1 = '0;
    b_idle();

    // exp = {gnt0, gnt1, wren, rvalid0, rvalid1, busy}
    // reset held with both requesting
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(1, 1,0,0,4'd1,0, 1,0,0,4'd2,0, 6'b000000, 0));
    // contention, reads alternate
    tv.push_back(mk(0, 1,0,0,4'd1,0, 1,0,0,4'd2,0, 6'b100000, 0));
    tv.push_back(mk(0, 1,0,0,4'd3,0, 1,0,0,4'd2,0, 6'b010101, 8'h04));
    tv.push_back(mk(0, 1,0,0,4'd3,0, 1,0,0,4'd4,0, 6'b100011, 8'h08));
    tv.push_back(mk(0, 0,0,0,4'd3,0, 1,0,0,4'd4,0, 6'b010101, 8'h0C));
    tv.push_back(mk(0, 0,0,0,4'd0,0, 0,0,0,4'd0,0, 6'b000011, 8'h10));
    // locked burst by port 0
    tv.push_back(mk(0, 1,1,0,4'd5,0, 1,0,0,4'd5,0, 6'b100000, 0));
    tv.push_back(mk(0, 1,1,0,4'd6,0, 1,0,0,4'd5,0, 6'b100101, 8'h14));
    tv.push_back(mk(0, 1,0,1,4'd5,8'hA0, 1,0,0,4'd5,0, 6'b101101, 8'h18));
    tv.push_back(mk(0, 0,0,0,4'd5,0, 1,0,0,4'd5,0, 6'b010000, 0));
    tv.push_back(mk(0, 0,0,0,4'd0,0, 0,0,0,4'd0,0, 6'b000011, 8'hA0));
    // reset right after a locked read by port 1
    tv.push_back(mk(0, 0,0,0,4'd0,0, 1,1,0,4'd7,0, 6'b010000, 0));
    tv.push_back(mk(1, 1,0,0,4'd9,0, 1,1,0,4'd7,0, 6'b000000, 0));
    tv.push_back(mk(0, 1,0,0,4'd9,0, 1,0,0,4'd7,0, 6'b100000, 0));
    tv.push_back(mk(0, 0,0,0,4'd9,0, 1,0,0,4'd7,0, 6'b010101, 8'h24));
    tv.push_back(mk(0, 0,0,0,4'd0,0, 0,0,0,4'd0,0, 6'b000011, 8'h1C));

    ld = 1'b1;
    R  = 1'b1;
    repeat (2) @(negedge C);
    ld = 1'b0;

    foreach (tv[i]) begin
      @(negedge C);
      R = tv[i].r;
      ifa.req0 = tv[i].q0; ifa.lock0 = tv[i].l0; ifa.we0 = tv[i].w0;
      ifa.addr0 = tv[i].a0; ifa.wdata0 = tv[i].d0;
      ifa.req1 = tv[i].q1; ifa.lock1 = tv[i].l1; ifa.we1 = tv[i].w1;
      ifa.addr1 = tv[i].a1; ifa.wdata1 = tv[i].d1;
      #1;
      o = {ifa.gnt0, ifa.gnt1, ifa.ram_wren,
           ifa.rvalid0, ifa.rvalid1, ifa.busy};
      chk($sformatf("vec%0d_outs", i), int'(o), int'(tv[i].ex));
      if (tv[i].ex[2] | tv[i].ex[1])
        chk($sformatf("vec%0d_rdata", i), int'(ifa.rdata),
            int'(tv[i].erd));
    end

    // forced release on instance b
    @(negedge C);
    R = 1'b1;
    ifa.req0 = 1'b0; ifa.req1 = 1'b0;
    ifa.lock0 = 1'b0; ifa.lock1 = 1'b0; ifa.we0 = 1'b0;
    @(negedge C);
    R = 1'b0;
    ifb.req0 = 1'b1; ifb.lock0 = 1'b1; ifb.addr0 = 4'd0;
    ifb.req1 = 1'b1; ifb.addr1 = 4'd1;
    first = -1;
    idle_at = -1;
    n_g0 = 0;
    for (int k = 0; k < 12 && first < 0; k++) begin
      #1;
      if (ifb.gnt1) first = k;
      else if (ifb.gnt0) n_g0++;
      else idle_at = k;
      @(negedge C);
    end
    chk("fr_gnt0_count", n_g0, 4);
    chk("fr_idle_cycle", idle_at, 4);
    chk("fr_gnt1_cycle", first, 5);

    // single read latency on instance b
    b_idle();
    R = 1'b1;
    @(negedge C);
    R = 1'b0;
    ifb.req1 = 1'b1; ifb.addr1 = 4'd15;
    #1;
    chk("lat_gnt1", int'(ifb.gnt1), 1);
    @(negedge C);
    ifb.req1 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("lat_rv_c%0d", k),
          int'({ifb.rvalid0, ifb.rvalid1}), (k == 2) ? 1 : 0);
      if (k == 2) chk("lat_rdata", int'(ifb.rdata), 'h3C);
      if (k == 1) chk("lat_busy", int'(ifb.busy), 1);
      @(negedge C);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
